// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with runtime CPOL/CPHA, configurable width,
// SCK divider and bit order, behind a valid/ready request port.
module spi_master_cfg #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              cpol,
   input  logic              cpha,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              sck,
   output logic              cs_n,
   output logic              mosi,
   input  logic              miso
);

   localparam int HW = $clog2(CLK_DIV + 1);
   localparam int EW = $clog2(2 * DATA_W + 1);
   localparam logic [HW-1:0] H_END  = HW'(CLK_DIV - 1);
   localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE, LEAD, XFER, TRAIL, DONE
   } state_t;

   state_t            state;
   logic [HW-1:0]     hcnt;
   logic [EW-1:0]     ecnt;
   logic              cpha_q;
   logic [DATA_W-1:0] tsh;
   logic [DATA_W-1:0] rsh;

   logic h_end;
   logic lead;
   logic last;
   logic adv;
   logic smp;

   function automatic logic head(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? v[DATA_W-1] : v[0];
   endfunction

   function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? (v << 1) : (v >> 1);
   endfunction

   function automatic logic [DATA_W-1:0] ins(
      input logic [DATA_W-1:0] v,
      input logic              b
   );
      return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
   endfunction

   // ecnt counts edges already emitted, so an even count means the
   // next edge is a leading one
   assign h_end = (hcnt == H_END);
   assign lead  = ~ecnt[0];
   assign last  = (ecnt == E_LAST);
   assign adv   = cpha_q ? lead : (~lead & ~last);
   assign smp   = cpha_q ? ~lead : lead;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hcnt     <= '0;
         ecnt     <= '0;
         cpha_q   <= 1'b0;
         tsh      <= '0;
         rsh      <= '0;
         tx_ready <= 1'b1;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         busy     <= 1'b0;
         sck      <= 1'b0;
         cs_n     <= 1'b1;
         mosi     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               sck <= cpol;
               if (tx_valid) begin
                  state    <= LEAD;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  cs_n     <= 1'b0;
                  hcnt     <= '0;
                  ecnt     <= '0;
                  rsh      <= '0;
                  cpha_q   <= cpha;
                  if (cpha) begin
                     tsh <= tx_data;
                  end else begin
                     tsh  <= shl(tx_data);
                     mosi <= head(tx_data);
                  end
               end
            end
            LEAD, XFER: begin
               if (h_end) begin
                  hcnt <= '0;
                  sck  <= ~sck;
                  ecnt <= ecnt + 1'b1;
                  if (adv) begin
                     mosi <= head(tsh);
                     tsh  <= shl(tsh);
                  end
                  if (smp) rsh <= ins(rsh, miso);
                  state <= last ? TRAIL : XFER;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            TRAIL: begin
               if (h_end) begin
                  hcnt     <= '0;
                  state    <= DONE;
                  cs_n     <= 1'b1;
                  rx_valid <= 1'b1;
                  rx_data  <= rsh;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               tx_ready <= 1'b1;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: two instances (8b/div2/MSB, 16b/div1/LSB),
// a timing model per instance and directed transfers with literal checks.
module tb_spi_master_cfg;

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b0;
   int   cyc     = 0;
   int   checks  = 0;
   int   errors  = 0;

   always #5 clk_50m = ~clk_50m;
   always @(posedge clk_50m) cyc++;

   logic        a_tx_valid = 1'b0, a_cpol = 1'b0, a_cpha = 1'b0;
   logic        a_loop = 1'b1, a_sl_miso = 1'b0, a_miso;
   logic [7:0]  a_tx_data = '0, a_resp = '0, a_rx_data;
   logic        a_tx_ready, a_rx_valid, a_busy, a_sck, a_cs_n, a_mosi;

   logic        b_tx_valid = 1'b0, b_cpol = 1'b0, b_cpha = 1'b0;
   logic        b_loop = 1'b1, b_sl_miso = 1'b0, b_miso;
   logic [15:0] b_tx_data = '0, b_resp = '0, b_rx_data;
   logic        b_tx_ready, b_rx_valid, b_busy, b_sck, b_cs_n, b_mosi;

   assign a_miso = a_loop ? a_mosi : a_sl_miso;
   assign b_miso = b_loop ? b_mosi : b_sl_miso;

   spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (
      .clk_50m(clk_50m), .rst_n(rst_n),
      .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
      .tx_data(a_tx_data), .cpol(a_cpol), .cpha(a_cpha),
      .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy),
      .sck(a_sck), .cs_n(a_cs_n), .mosi(a_mosi), .miso(a_miso)
   );

   spi_master_cfg #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
      .clk_50m(clk_50m), .rst_n(rst_n),
      .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .tx_data(b_tx_data), .cpol(b_cpol), .cpha(b_cpha),
      .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy),
      .sck(b_sck), .cs_n(b_cs_n), .mosi(b_mosi), .miso(b_miso)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // bit position (in shift order) present after n sck edges
   function automatic int bidx(input int n, input logic ph, input int w);
      int i;
      i = ph ? ((n > 0) ? (n - 1) / 2 : 0) : n / 2;
      if (i > w - 1) i = w - 1;
      return i;
   endfunction

   function automatic logic bit_of(input logic [31:0] v, input int i,
                                   input int w, input logic msb);
      return msb ? v[w-1-i] : v[i];
   endfunction

   // ---------------- slave devices ----------------
   int   a_se = 0, b_se = 0;
   logic a_sps = 1'b0, b_sps = 1'b0, a_sph = 1'b0, b_sph = 1'b0;

   always @(negedge clk_50m) begin
      if (a_cs_n) begin a_se = 0; a_sph = a_cpha; end
      else if (a_sck != a_sps) a_se++;
      a_sps = a_sck;
      a_sl_miso = bit_of(32'(a_resp), bidx(a_se, a_sph, 8), 8, 1'b1);
      if (b_cs_n) begin b_se = 0; b_sph = b_cpha; end
      else if (b_sck != b_sps) b_se++;
      b_sps = b_sck;
      b_sl_miso = bit_of(32'(b_resp), bidx(b_se, b_sph, 16), 16, 1'b0);
   end

   // ---------------- timing model ----------------
   int          m_w[2]   = '{8, 16};
   int          m_d[2]   = '{2, 1};
   logic        m_msb[2] = '{1'b1, 1'b0};
   logic        m_act[2] = '{1'b0, 1'b0};
   int          m_t0[2]  = '{0, 0};
   logic [31:0] m_tx[2]  = '{0, 0};
   logic [31:0] m_rxw[2] = '{0, 0};
   logic [31:0] m_rxd[2] = '{0, 0};
   logic        m_cpol[2] = '{1'b0, 1'b0};
   logic        m_cpha[2] = '{1'b0, 1'b0};
   logic        m_isck[2] = '{1'b0, 1'b0};
   logic        m_mosi[2] = '{1'b0, 1'b0};

   task automatic step(input int id, input logic txv, input logic [31:0] txd,
                       input logic cp, input logic ph, input logic lp,
                       input logic [31:0] rsp, input logic rdy,
                       input logic rxv, input logic [31:0] rxd,
                       input logic bsy, input logic sk, input logic cs,
                       input logic mo);
      int   w, dv, d, n, dd;
      logic e_cs, e_rxv, e_bsy, e_rdy, e_sck;
      string p;
      w  = m_w[id];
      dv = m_d[id];
      dd = (2 * w + 1) * dv + 1;
      d  = 0;
      p  = $sformatf("dut%0d.", id);
      if (!rst_n) begin
         m_act[id] = 1'b0; m_rxd[id] = '0;
         m_isck[id] = 1'b0; m_mosi[id] = 1'b0;
         e_cs = 1; e_rxv = 0; e_bsy = 0; e_rdy = 1; e_sck = 0;
      end else if (m_act[id]) begin
         d = cyc - m_t0[id];
         n = (d - 1) / dv;
         if (n > 2 * w) n = 2 * w;
         e_cs = (d == dd); e_rxv = (d == dd);
         e_bsy = 1; e_rdy = 0;
         e_sck = m_cpol[id] ^ (n % 2 == 1);
         if (!m_cpha[id] || n > 0)
            m_mosi[id] = bit_of(m_tx[id], bidx(n, m_cpha[id], w), w, m_msb[id]);
         if (d == dd) m_rxd[id] = m_rxw[id];
      end else begin
         e_cs = 1; e_rxv = 0; e_bsy = 0; e_rdy = 1; e_sck = m_isck[id];
      end
      chk({p, "tx_ready"}, rdy, e_rdy);
      chk({p, "busy"}, bsy, e_bsy);
      chk({p, "cs_n"}, cs, e_cs);
      chk({p, "rx_valid"}, rxv, e_rxv);
      chk({p, "sck"}, sk, e_sck);
      chk({p, "mosi"}, mo, m_mosi[id]);
      chk({p, "rx_data"}, rxd, m_rxd[id]);
      if (rst_n) begin
         if (m_act[id]) begin
            m_isck[id] = m_cpol[id];
            if (d == dd) m_act[id] = 1'b0;
         end else begin
            m_isck[id] = cp;
            if (txv) begin
               m_act[id] = 1'b1; m_t0[id] = cyc; m_tx[id] = txd;
               m_cpol[id] = cp; m_cpha[id] = ph;
               m_rxw[id] = lp ? txd : rsp;
            end
         end
      end
   endtask

   always @(negedge clk_50m) begin
      step(0, a_tx_valid, 32'(a_tx_data), a_cpol, a_cpha, a_loop,
           32'(a_resp), a_tx_ready, a_rx_valid, 32'(a_rx_data), a_busy,
           a_sck, a_cs_n, a_mosi);
      step(1, b_tx_valid, 32'(b_tx_data), b_cpol, b_cpha, b_loop,
           32'(b_resp), b_tx_ready, b_rx_valid, 32'(b_rx_data), b_busy,
           b_sck, b_cs_n, b_mosi);
   end

   // ---------------- monitors on instance a ----------------
   int         a_rise = 0, a_rxn = 0, a_run = 0, a_gap = 0;
   logic [7:0] a_sq = '0;
   logic       a_mps = 1'b0;

   always @(negedge clk_50m) begin
      if (!a_cs_n && a_sck && !a_mps) begin
         a_rise++;
         a_sq = {a_sq[6:0], a_mosi};
      end
      a_mps = a_sck;
      if (a_rx_valid) a_rxn++;
      if (a_cs_n) a_run++;
      else begin
         if (a_run > 0) a_gap = a_run;
         a_run = 0;
      end
   end

   // ---------------- driver ----------------
   task automatic send(input int id, input logic [31:0] tx, input logic cp,
                       input logic ph, input logic lp, input logic [31:0] rsp,
                       output int t0, output int td, output logic fm);
      @(posedge clk_50m); #1;
      if (id == 0) begin
         a_tx_valid = 1; a_tx_data = tx[7:0]; a_cpol = cp; a_cpha = ph;
         a_loop = lp; a_resp = rsp[7:0];
      end else begin
         b_tx_valid = 1; b_tx_data = tx[15:0]; b_cpol = cp; b_cpha = ph;
         b_loop = lp; b_resp = rsp[15:0];
      end
      t0 = -1; td = -1; fm = 1'b0;
      for (int i = 0; i < 200 && t0 < 0; i++) begin
         @(negedge clk_50m);
         if ((id == 0) ? a_tx_ready : b_tx_ready) t0 = cyc;
      end
      @(posedge clk_50m); #1;
      if (id == 0) begin
         a_tx_valid = 0; a_tx_data = ~tx[7:0]; a_cpha = ~ph;
      end else begin
         b_tx_valid = 0; b_tx_data = ~tx[15:0]; b_cpha = ~ph;
      end
      for (int i = 0; i < 200 && td < 0; i++) begin
         @(negedge clk_50m);
         if (i == 0) fm = (id == 0) ? a_mosi : b_mosi;
         if ((id == 0) ? a_rx_valid : b_rx_valid) td = cyc;
      end
      chk("transfer_completes", (t0 >= 0 && td >= 0), 1);
      @(posedge clk_50m); #1;
      if (id == 0) a_cpha = ph;
      else b_cpha = ph;
   endtask

   int   t0, td, t0b, snap;
   logic fm;

   initial begin
      #500us;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      repeat (3) @(posedge clk_50m);
      @(negedge clk_50m);
      chk("rst_tx_ready", a_tx_ready, 1);
      chk("rst_cs_n", a_cs_n, 1);
      chk("rst_sck", a_sck, 0);
      chk("rst_rx_data", b_rx_data, 0);
      @(posedge clk_50m); #1;
      rst_n = 1;
      repeat (2) @(posedge clk_50m);

      // mode 0 loopback
      a_rise = 0;
      send(0, 32'hA5, 0, 0, 1, 0, t0, td, fm);
      chk("t1_latency", td - t0, 35);
      chk("t1_rx", a_rx_data, 8'hA5);
      chk("t1_rising", a_rise, 8);

      // mode 3 with slave response
      a_rise = 0; a_sq = '0;
      send(0, 32'hC3, 1, 1, 0, 32'h3C, t0, td, fm);
      chk("t2_rx", a_rx_data, 8'h3C);
      chk("t2_mosi_seq", a_sq, 8'hC3);
      @(negedge clk_50m);
      chk("t2_idle_sck", a_sck, 1);

      // modes 1 and 2
      send(0, 32'hC3, 0, 1, 0, 32'h3C, t0, td, fm);
      chk("t3_mode1_rx", a_rx_data, 8'h3C);
      send(0, 32'hC3, 1, 0, 0, 32'h3C, t0, td, fm);
      chk("t3_mode2_rx", a_rx_data, 8'h3C);

      // tx_valid held across two words
      snap = a_rxn;
      @(posedge clk_50m); #1;
      a_loop = 1; a_cpol = 0; a_cpha = 0; a_tx_data = 8'h01; a_tx_valid = 1;
      t0 = -1;
      for (int i = 0; i < 100 && t0 < 0; i++) begin
         @(negedge clk_50m);
         if (a_tx_ready) t0 = cyc;
      end
      @(posedge clk_50m); #1;
      a_tx_data = 8'h02;
      t0b = -1;
      for (int i = 0; i < 100 && t0b < 0; i++) begin
         @(negedge clk_50m);
         if (a_tx_ready) t0b = cyc;
      end
      @(posedge clk_50m); #1;
      a_tx_valid = 0;
      repeat (80) @(negedge clk_50m);
      chk("t4_pulses", a_rxn - snap, 2);
      chk("t4_cs_gap", a_gap, 2);
      chk("t4_spacing", t0b - t0, 36);
      chk("t4_rx", a_rx_data, 8'h02);

      // reset at sck edge 5
      snap = a_rxn;
      @(posedge clk_50m); #1;
      a_loop = 1; a_cpol = 1; a_cpha = 0; a_tx_data = 8'h96; a_tx_valid = 1;
      t0 = -1;
      for (int i = 0; i < 100 && t0 < 0; i++) begin
         @(negedge clk_50m);
         if (a_tx_ready) t0 = cyc;
      end
      @(posedge clk_50m); #1;
      a_tx_valid = 0;
      repeat (10) @(posedge clk_50m);
      #1 rst_n = 0;
      @(negedge clk_50m);
      chk("t5_cs_n", a_cs_n, 1);
      chk("t5_sck", a_sck, 0);
      repeat (2) @(posedge clk_50m);
      #1 rst_n = 1;
      repeat (60) @(negedge clk_50m);
      chk("t5_no_rx_valid", a_rxn - snap, 0);
      send(0, 32'h5A, 1, 0, 1, 0, t0, td, fm);
      chk("t5_fresh_rx", a_rx_data, 8'h5A);

      // 16-bit, divide-by-1, LSB first
      send(1, 32'h8001, 0, 0, 1, 0, t0, td, fm);
      chk("t6_latency", td - t0, 34);
      chk("t6_rx", b_rx_data, 16'h8001);
      send(1, 32'h0001, 0, 0, 0, 32'h1234, t0, td, fm);
      chk("t6_first_bit_lsb", fm, 1);
      chk("t6_slave_rx", b_rx_data, 16'h1234);
      send(1, 32'hA5C3, 1, 1, 0, 32'hBEEF, t0, td, fm);
      chk("t6_mode3_rx", b_rx_data, 16'hBEEF);

      repeat (4) @(negedge clk_50m);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
